// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared word, access-width and memory-arbiter types
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  localparam int LDST_WIDTH_W = 2;
  localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    INST,
    DATA
  } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter for one shared single-port memory
// Define MEM_ARB_RR_EN to alternate grants on conflicts; otherwise data always wins.
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    imem_ren,
  input  word_t                   imem_addr,
  output word_t                   imem_load,
  output logic                    ihit,
  input  logic                    dmem_ren,
  input  logic                    dmem_wen,
  input  word_t                   dmem_addr,
  input  word_t                   dmem_store,
  input  logic [LDST_WIDTH_W-1:0] dmem_width,
  output word_t                   dmem_load,
  output logic                    dhit,
  output logic                    ram_ren,
  output logic                    ram_wen,
  output word_t                   ram_addr,
  output word_t                   ram_store,
  output logic [LDST_WIDTH_W-1:0] ram_width,
  input  word_t                   ram_load,
  input  logic                    ram_ready,
  output logic [STALL_CNT_W-1:0]  istall_cnt,
  output logic [STALL_CNT_W-1:0]  dstall_cnt
);

  arb_state_t              state_q, state_d;
  word_t                   addr_q, addr_d;
  word_t                   store_q, store_d;
  logic [LDST_WIDTH_W-1:0] width_q, width_d;
  logic                    wen_q, wen_d;
  logic [STALL_CNT_W-1:0]  istall_q, istall_d;
  logic [STALL_CNT_W-1:0]  dstall_q, dstall_d;
  logic                    i_req, d_req;
  arb_grant_t              grant;

  assign i_req = imem_ren;
  assign d_req = dmem_ren | dmem_wen;

`ifdef MEM_ARB_RR_EN
  arb_grant_t last_q, last_d;

  always_comb begin
    if (i_req && d_req) begin
      grant = (last_q == DATA) ? INST : DATA;
    end else begin
      grant = d_req ? DATA : INST;
    end
  end
`else
  assign grant = d_req ? DATA : INST;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    width_d   = width_q;
    wen_d     = wen_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    imem_load = '0;
    dmem_load = '0;
`ifdef MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
          last_d = grant;
`endif
          if (grant == DATA) begin
            state_d = BUSY_D;
            addr_d  = dmem_addr;
            store_d = dmem_store;
            width_d = dmem_width;
            wen_d   = dmem_wen;
          end else begin
            state_d = BUSY_I;
            addr_d  = imem_addr;
            store_d = '0;
            width_d = LDST_WORD;
            wen_d   = 1'b0;
          end
        end
      end
      BUSY_I: begin
        ram_ren = 1'b1;
        if (ram_ready) begin
          ihit      = 1'b1;
          imem_load = ram_load;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        // A simultaneous read+write request was latched as a write.
        ram_ren = ~wen_q;
        ram_wen = wen_q;
        if (ram_ready) begin
          dhit      = 1'b1;
          dmem_load = ram_load;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    istall_d = istall_q;
    dstall_d = dstall_q;
    if (imem_ren && !ihit && (istall_q != '1)) begin
      istall_d = istall_q + STALL_CNT_W'(1);
    end
    if (d_req && !dhit && (dstall_q != '1)) begin
      dstall_d = dstall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      width_q  <= '0;
      wen_q    <= 1'b0;
      istall_q <= '0;
      dstall_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q   <= DATA;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      width_q  <= width_d;
      wen_q    <= wen_d;
      istall_q <= istall_d;
      dstall_q <= dstall_d;
`ifdef MEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign ram_addr   = addr_q;
  assign ram_store  = store_q;
  assign ram_width  = width_q;
  assign istall_cnt = istall_q;
  assign dstall_cnt = dstall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
// Expected grant order follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
  import rv32ima_pkg::*;

  typedef struct {
    bit    is_d;
    bit    wr;
    word_t addr;
    word_t store;
    word_t load;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    imem_ren, dmem_ren, dmem_wen, ram_ready;
  word_t                   imem_addr, dmem_addr, dmem_store, ram_load;
  logic [LDST_WIDTH_W-1:0] dmem_width;
  word_t                   imem_load, dmem_load, ram_addr, ram_store;
  logic                    ihit, dhit, ram_ren, ram_wen;
  logic [LDST_WIDTH_W-1:0] ram_width;
  logic [3:0]              istall_cnt, dstall_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.STALL_CNT_W(4)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width), .dmem_load(dmem_load), .dhit(dhit),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_width(ram_width), .ram_load(ram_load), .ram_ready(ram_ready),
    .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    imem_ren   = 1'b0;
    imem_addr  = '0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_store = '0;
    dmem_width = 2'd2;
    ram_ready  = 1'b0;
    ram_load   = '0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    clear_inputs();
    tick();
    tick();
    nrst = 1'b1;
  endtask

  // Called in an IDLE cycle with requests already driven; serves one grant.
  task automatic run_txn(input bit is_d, input bit wr, input word_t addr, input word_t store,
                         input int lat, input word_t load, input bit mid_change);
    exp_t item;
    sb.push_back('{is_d, wr, addr, store, load});
    #1;
    chk("idle_ren", ram_ren, 0);
    chk("idle_wen", ram_wen, 0);
    tick();
    for (int i = 1; i <= lat; i++) begin
      if (mid_change && i == 1) imem_addr = 32'h300;
      ram_ready = (i == lat);
      ram_load  = (i == lat) ? load : 32'hBAD0_BAD0;
      #1;
      chk("ram_addr", ram_addr, sb[0].addr);
      chk("ram_wen", ram_wen, wr);
      chk("ram_ren", ram_ren, !wr);
      chk("ram_width", ram_width, 2'd2);
      if (wr) chk("ram_store", ram_store, sb[0].store);
      if (i == lat) begin
        item = sb.pop_front();
        chk("ihit", ihit, !item.is_d);
        chk("dhit", dhit, item.is_d);
        chk("hit_load", item.is_d ? dmem_load : imem_load, item.load);
        chk("other_load", item.is_d ? imem_load : dmem_load, 0);
      end else begin
        chk("early_hit", {ihit, dhit}, 0);
        chk("early_load", imem_load | dmem_load, 0);
      end
      tick();
    end
    ram_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] order;
    bit         rr;
    nrst = 1'b0;
    clear_inputs();
    ram_ready = 1'b1;
    ram_load  = 32'h1234_5678;
    tick();
    #1;
    chk("rst_ram_ren", ram_ren, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_store", ram_store, 0);
    chk("rst_ram_width", ram_width, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    chk("rst_loads", imem_load | dmem_load, 0);
    chk("rst_istall", istall_cnt, 0);
    chk("rst_dstall", dstall_cnt, 0);
    do_reset();

    // Lone fetch, 3-cycle memory, address changes mid-transaction.
    imem_ren  = 1'b1;
    imem_addr = 32'h100;
    run_txn(0, 0, 32'h100, 0, 3, 32'h0000_0013, 1);
    chk("fetch_istall", istall_cnt, 3);
    chk("fetch_dstall", dstall_cnt, 0);
    imem_ren = 1'b0;
    tick();

    // Read+write together is a write.
    do_reset();
    dmem_ren   = 1'b1;
    dmem_wen   = 1'b1;
    dmem_addr  = 32'h40;
    dmem_store = 32'hDEAD_BEEF;
    run_txn(1, 1, 32'h40, 32'hDEAD_BEEF, 2, 32'h0BAD_F00D, 0);
    chk("write_dstall", dstall_cnt, 2);
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    tick();

    // Conflicting fetch 0x200 and load 0x8000 at minimum latency.
    do_reset();
`ifdef MEM_ARB_RR_EN
    rr    = 1'b1;
    order = 4'b1010;
`else
    rr    = 1'b0;
    order = 4'b0111;
`endif
    imem_ren  = 1'b1;
    imem_addr = 32'h200;
    dmem_ren  = 1'b1;
    dmem_addr = 32'h8000;
    for (int k = 0; k < 4; k++) begin
      if (!rr && k == 3) dmem_ren = 1'b0;
      run_txn(order[k], 0, order[k] ? 32'h8000 : 32'h200, 0, 1, 32'h1000_0000 + k, 0);
    end
    clear_inputs();
    tick();

    // Reset while a data transaction is outstanding.
    do_reset();
    dmem_ren  = 1'b1;
    dmem_addr = 32'h80;
    tick();
    #1;
    chk("busy_d_ren", ram_ren, 1);
    nrst = 1'b0;
    #1;
    chk("abort_ren", ram_ren, 0);
    chk("abort_wen", ram_wen, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_dhit", dhit, 0);
    dmem_ren = 1'b0;
    tick();
    nrst      = 1'b1;
    ram_ready = 1'b1;
    ram_load  = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("late_ready_hits", {ihit, dhit}, 0);
      chk("late_ready_load", dmem_load, 0);
      chk("late_ready_ren", ram_ren, 0);
      tick();
    end
    ram_ready = 1'b0;

    // Stall counter saturation with a 4-bit counter.
    do_reset();
    imem_ren  = 1'b1;
    imem_addr = 32'h400;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("istall_sat", istall_cnt, (i > 15) ? 15 : i);
    end
    chk("sat_dstall", dstall_cnt, 0);
    do_reset();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
